// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-shifter (SLL/SRL/SRA/ROR), one register per shift stage, carrying a caller tag.
// Optional zero flag on the result is built when SHIFTER_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAGW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [SHW-1:0]   in_shamt_i,
    input  logic [1:0]       in_op_i,
    input  logic [TAGW-1:0]  in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [TAGW-1:0]  out_tag_o
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    output logic             out_zero_o
`endif
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Handshake: a transfer happens on a side when valid && ready are both high
    // at the rising edge. The whole pipe moves as one (global stall): it
    // advances when the last stage is empty or its result is being taken, and
    // bubbles stay in place. in_ready_o is that same advance term.
    logic advance;
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;

        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_shamt;
        logic [1:0]       src_op;
        logic [TAGW-1:0]  src_tag;
        logic             src_sign;
        logic             src_valid;
        logic [WIDTH-1:0] nxt_data;

        logic [WIDTH-1:0] data_q;
        logic [SHW-1:0]   shamt_q;
        logic [1:0]       op_q;
        logic [TAGW-1:0]  tag_q;
        logic             sign_q;
        logic             valid_q;

        if (k == 0) begin : g_head
            // The SRA fill bit is the operand's original MSB, captured once here.
            assign src_data  = in_data_i;
            assign src_shamt = in_shamt_i;
            assign src_op    = in_op_i;
            assign src_tag   = in_tag_i;
            assign src_sign  = in_data_i[WIDTH-1];
            assign src_valid = in_valid_i;
        end else begin : g_body
            assign src_data  = g_stage[k-1].data_q;
            assign src_shamt = g_stage[k-1].shamt_q;
            assign src_op    = g_stage[k-1].op_q;
            assign src_tag   = g_stage[k-1].tag_q;
            assign src_sign  = g_stage[k-1].sign_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        always_comb begin
            nxt_data = src_data;
            if (src_shamt[k]) begin
                case (src_op)
                    OP_SLL:  nxt_data = src_data << S;
                    OP_SRL:  nxt_data = src_data >> S;
                    OP_SRA:  nxt_data = ({WIDTH{src_sign}} << (WIDTH - S)) | (src_data >> S);
                    default: nxt_data = (src_data >> S) | (src_data << (WIDTH - S));
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q  <= '0;
                shamt_q <= '0;
                op_q    <= '0;
                tag_q   <= '0;
                sign_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= nxt_data;
                shamt_q <= src_shamt;
                op_q    <= src_op;
                tag_q   <= src_tag;
                sign_q  <= src_sign;
                valid_q <= src_valid;
            end
        end
    end

    assign out_valid_o = g_stage[SHW-1].valid_q;
    assign out_data_o  = g_stage[SHW-1].data_q;
    assign out_tag_o   = g_stage[SHW-1].tag_q;

    // Control fields of the last stage have no consumer beyond the pipe.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHW-1].shamt_q, g_stage[SHW-1].op_q, g_stage[SHW-1].sign_q};

`ifdef SHIFTER_ZERO_FLAG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_zero_o <= 1'b0;
        end else if (advance) begin
            out_zero_o <= g_stage[SHW-1].src_valid && (g_stage[SHW-1].nxt_data == '0);
        end
    end
`endif

endmodule
